// File: rtl/hex_seg_decoder_if.sv
// Digit-side bundle between the display scanner and the seven-segment decoder.
// The scanner uses the master modport and the decoder uses the slave modport.
interface hex_seg_decoder_if;
  logic       en;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] seg;

  modport master (output en, output blank, output digit, input seg);
  modport slave  (input en, input blank, input digit, output seg);
endinterface

// File: rtl/hex_seg_decoder.sv
// Registered hex-to-seven-segment decoder with hold and blanking. The segment
// pins are driven straight from flops, so seg never glitches.
module hex_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  hex_seg_decoder_if.slave  bus
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] glyph_al;  // glyph in common-anode form (0 = lit)
  logic [6:0] glyph;
  logic [6:0] seg_d;
  // The initialiser gives the off pattern at power-up and at time zero in simulation.
  logic [6:0] seg_q = SEG_OFF;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    glyph_al = 7'h7F;
    unique case (bus.digit)
      4'h0: glyph_al = 7'h40;
      4'h1: glyph_al = 7'h79;
      4'h2: glyph_al = 7'h24;
      4'h3: glyph_al = 7'h30;
      4'h4: glyph_al = 7'h19;
      4'h5: glyph_al = 7'h12;
      4'h6: glyph_al = 7'h02;
      4'h7: glyph_al = 7'h78;
      4'h8: glyph_al = 7'h00;
      4'h9: glyph_al = 7'h10;
      4'hA: glyph_al = 7'h08;
      4'hB: glyph_al = 7'h03;
      4'hC: glyph_al = 7'h46;
      4'hD: glyph_al = 7'h21;
      4'hE: glyph_al = 7'h06;
      4'hF: glyph_al = 7'h0E;
      default: glyph_al = 7'h7F;
    endcase
    glyph = ACTIVE_LOW ? glyph_al : ~glyph_al;
  end

  always_comb begin
    seg_d = seg_q;
    if (bus.en) begin
      seg_d = bus.blank ? SEG_OFF : glyph;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  // NOTE: reset is synchronous and wins over the hold; seg_q is the only state in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.seg = seg_q;

endmodule

// File: tb/tb_hex_seg_decoder.sv
// Bench for hex_seg_decoder: a segment-letter model checked every cycle on both
// polarities, plus directed vectors with hand-computed literal expectations.
module tb_hex_seg_decoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hex_seg_decoder_if bus_al ();
  hex_seg_decoder_if bus_ah ();

  hex_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst(rst), .bus(bus_al.slave));
  hex_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (.clk(clk), .rst(rst), .bus(bus_ah.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Lit segments per glyph, by letter a..g.
  string lit_set [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] model_glyph(input logic [3:0] d, input bit active_low);
    logic [6:0] lit;
    string s;
    lit = 7'h00;
    s = lit_set[d];
    for (int i = 0; i < s.len(); i++) lit[s[i] - "a"] = 1'b1;
    return active_low ? ~lit : lit;
  endfunction

  function automatic logic [6:0] model_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  logic [6:0] exp_al = 7'h7F;
  logic [6:0] exp_ah = 7'h00;

  // Model register: applies the load-priority rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_al = model_off(1'b1);
      exp_ah = model_off(1'b0);
    end else if (bus_al.en) begin
      exp_al = bus_al.blank ? model_off(1'b1) : model_glyph(bus_al.digit, 1'b1);
      exp_ah = bus_ah.blank ? model_off(1'b0) : model_glyph(bus_ah.digit, 1'b0);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    check("model_al", bus_al.seg, exp_al);
    check("model_ah", bus_ah.seg, exp_ah);
  end

  task automatic step(input logic r, input logic e, input logic b, input logic [3:0] d);
    rst          = r;
    bus_al.en    = e;
    bus_al.blank = b;
    bus_al.digit = d;
    bus_ah.en    = e;
    bus_ah.blank = b;
    bus_ah.digit = d;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] table_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    rst          = 1'b1;
    bus_al.en    = 1'b1;
    bus_al.blank = 1'b0;
    bus_al.digit = 4'h8;
    bus_ah.en    = 1'b1;
    bus_ah.blank = 1'b0;
    bus_ah.digit = 4'h8;
    #1;
    check("init_al", bus_al.seg, 7'h7F);
    check("init_ah", bus_ah.seg, 7'h00);

    // Reset held two cycles with digit 8, then released.
    step(1'b1, 1'b1, 1'b0, 4'h8);
    check("rst1_al", bus_al.seg, 7'h7F);
    step(1'b1, 1'b1, 1'b0, 4'h8);
    check("rst2_al", bus_al.seg, 7'h7F);
    check("rst2_ah", bus_ah.seg, 7'h00);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    check("post_rst_al", bus_al.seg, 7'h00);
    check("post_rst_ah", bus_ah.seg, 7'h7F);

    // Full table sweep.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i));
      check($sformatf("sweep_%0h", i), bus_al.seg, table_al[i]);
    end

    // Hold: load 3, then change digit to 5 with en low.
    step(1'b0, 1'b1, 1'b0, 4'h3);
    check("hold_load", bus_al.seg, 7'h30);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h5);
      check($sformatf("hold_%0d", i), bus_al.seg, 7'h30);
    end
    step(1'b0, 1'b0, 1'b1, 4'h5);
    check("hold_blank_ignored", bus_al.seg, 7'h30);
    step(1'b0, 1'b1, 1'b0, 4'h5);
    check("hold_release", bus_al.seg, 7'h12);

    // Blank toggling on digit A.
    step(1'b0, 1'b1, 1'b1, 4'hA);
    check("blank_on", bus_al.seg, 7'h7F);
    step(1'b0, 1'b1, 1'b0, 4'hA);
    check("blank_off", bus_al.seg, 7'h08);
    step(1'b0, 1'b1, 1'b1, 4'hA);
    check("blank_on2", bus_al.seg, 7'h7F);
    check("blank_on2_ah", bus_ah.seg, 7'h00);

    // Active-high polarity.
    step(1'b0, 1'b1, 1'b0, 4'h0);
    check("pol_0", bus_ah.seg, 7'h3F);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    check("pol_8", bus_ah.seg, 7'h7F);

    // Priority: reset overrides hold.
    step(1'b0, 1'b1, 1'b0, 4'h1);
    check("pre_prio", bus_al.seg, 7'h79);
    step(1'b1, 1'b0, 1'b0, 4'h1);
    check("prio_al", bus_al.seg, 7'h7F);
    check("prio_ah", bus_ah.seg, 7'h00);
    step(1'b0, 1'b0, 1'b0, 4'h1);
    check("prio_hold_off", bus_al.seg, 7'h7F);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    check("prio_resume", bus_al.seg, 7'h79);

    // Spot check of the model itself.
    check("model_pin_b", model_glyph(4'hB, 1'b1), 7'h03);
    check("model_pin_c", model_glyph(4'hC, 1'b0), 7'h39);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
